// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter with lockable bursts for the single-port data RAM.
// Optional macro DMARB_LOCK_LIMIT_EN caps a locked burst at MAX_LOCK grants when the other port waits.
module data_mem_arbiter #(
   parameter int XLEN     = 32,
   parameter int AW       = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p0_req_i,
   input  logic            p0_we_i,
   input  logic            p0_lock_i,
   input  logic [AW-1:0]   p0_addr_i,
   input  logic [XLEN-1:0] p0_wdata_i,
   output logic            p0_gnt_o,
   output logic            p0_rvalid_o,
   input  logic            p1_req_i,
   input  logic            p1_we_i,
   input  logic            p1_lock_i,
   input  logic [AW-1:0]   p1_addr_i,
   input  logic [XLEN-1:0] p1_wdata_i,
   output logic            p1_gnt_o,
   output logic            p1_rvalid_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            mem_en_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic [XLEN-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

   if (MAX_LOCK < 2 || MAX_LOCK > 255) begin : g_bad_max_lock
      $error("data_mem_arbiter: MAX_LOCK must be in 2..255");
   end

   state_t            state_q, state_d;
   logic              rr_last_q, rr_last_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_src_q, rd_src_d;
   logic [XLEN-1:0]   rdata_q;
   logic              gnt0_s, gnt1_s;

`ifdef DMARB_LOCK_LIMIT_EN
   localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);
   logic [7:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc_s;
   assign lock_cnt_inc_s = (lock_cnt_q == 8'hFF) ? lock_cnt_q : lock_cnt_q + 8'd1;
`endif

   // State, round-robin pointer and read-return registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_last_q  <= 1'b1;
         rd_pend_q  <= 1'b0;
         rd_src_q   <= 1'b0;
         rdata_q    <= '0;
`ifdef DMARB_LOCK_LIMIT_EN
         lock_cnt_q <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         rd_pend_q  <= rd_pend_d;
         rd_src_q   <= rd_src_d;
         if (rd_pend_q) rdata_q <= mem_rdata_i;
`ifdef DMARB_LOCK_LIMIT_EN
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   // Next state: lock entry/exit and round-robin pointer update
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      rd_pend_d = (gnt0_s | gnt1_s) & ~mem_we_o;
      rd_src_d  = gnt1_s;
`ifdef DMARB_LOCK_LIMIT_EN
      lock_cnt_d = lock_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt0_s) begin
               rr_last_d = 1'b0;
               state_d   = p0_lock_i ? LOCK0 : IDLE;
            end else if (gnt1_s) begin
               rr_last_d = 1'b1;
               state_d   = p1_lock_i ? LOCK1 : IDLE;
            end else begin
               state_d = IDLE;
            end
`ifdef DMARB_LOCK_LIMIT_EN
            // The grant that opens a burst is the first one counted
            lock_cnt_d = 8'd1;
`endif
         end
         LOCK0: begin
            if (!p0_req_i || !p0_lock_i) begin
               state_d = IDLE;
            end else begin
`ifdef DMARB_LOCK_LIMIT_EN
               lock_cnt_d = lock_cnt_inc_s;
               if (lock_cnt_inc_s >= MAX_LOCK_C && p1_req_i) begin
                  state_d   = IDLE;
                  rr_last_d = 1'b0;
               end else begin
                  state_d = LOCK0;
               end
`else
               state_d = LOCK0;
`endif
            end
         end
         LOCK1: begin
            if (!p1_req_i || !p1_lock_i) begin
               state_d = IDLE;
            end else begin
`ifdef DMARB_LOCK_LIMIT_EN
               lock_cnt_d = lock_cnt_inc_s;
               if (lock_cnt_inc_s >= MAX_LOCK_C && p0_req_i) begin
                  state_d   = IDLE;
                  rr_last_d = 1'b1;
               end else begin
                  state_d = LOCK1;
               end
`else
               state_d = LOCK1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef DMARB_LOCK_LIMIT_EN
      if (state_d == IDLE) lock_cnt_d = 8'd0;
`endif
   end

   // Grant decode; gated by rst so nothing reaches the RAM during reset
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      case (state_q)
         IDLE: begin
            gnt0_s = p0_req_i & (~p1_req_i | rr_last_q);
            gnt1_s = p1_req_i & (~p0_req_i | ~rr_last_q);
         end
         LOCK0:   gnt0_s = p0_req_i;
         LOCK1:   gnt1_s = p1_req_i;
         default: begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
         end
      endcase
      if (!rst) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else begin
         gnt0_s = gnt0_s;
         gnt1_s = gnt1_s;
      end
   end

   assign p0_gnt_o    = gnt0_s;
   assign p1_gnt_o    = gnt1_s;
   assign mem_en_o    = gnt0_s | gnt1_s;
   assign mem_we_o    = gnt0_s ? p0_we_i    : (gnt1_s ? p1_we_i    : 1'b0);
   assign mem_addr_o  = gnt0_s ? p0_addr_i  : (gnt1_s ? p1_addr_i  : '0);
   assign mem_wdata_o = gnt0_s ? p0_wdata_i : (gnt1_s ? p1_wdata_i : '0);
   assign p0_rvalid_o = rd_pend_q & ~rd_src_q;
   assign p1_rvalid_o = rd_pend_q & rd_src_q;
   assign rdata_o     = rd_pend_q ? mem_rdata_i : rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed-vector bench for data_mem_arbiter with a small synchronous RAM model.
module tb_data_mem_arbiter;

   logic        clk, rst;
   logic        p0_req_i, p0_we_i, p0_lock_i, p1_req_i, p1_we_i, p1_lock_i;
   logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
   logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        mem_en_o, mem_we_o;
   logic [31:0] ram [0:63];
   int          n_vec = 0;
   int          n_err = 0;

   data_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_lock_i(p0_lock_i),
      .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
      .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
      .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_lock_i(p1_lock_i),
      .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
      .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
      .rdata_o(rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM, one cycle read latency
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) ram[mem_addr_o[7:2]] <= mem_wdata_o;
         else          mem_rdata_i <= ram[mem_addr_o[7:2]];
      end
   end

   task automatic set_p0(input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
      p0_req_i = req; p0_we_i = we; p0_lock_i = lock; p0_addr_i = addr; p0_wdata_i = wdata;
   endtask

   task automatic set_p1(input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
      p1_req_i = req; p1_we_i = we; p1_lock_i = lock; p1_addr_i = addr; p1_wdata_i = wdata;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      set_p1(1'b1, 1'b1, 1'b1, 32'h14, 32'h5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_vec++; if (p0_gnt_o !== 1'b0 || p1_gnt_o !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b%b expected 00", p0_gnt_o, p1_gnt_o); end
         n_vec++; if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL rst_mem: got en=%b addr=%h expected all 0", mem_en_o, mem_addr_o); end
         n_vec++; if (p0_rvalid_o !== 1'b0 || p1_rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rd: got rdata=%h expected 0", rdata_o); end
      end
      @(negedge clk);
      rst = 1'b1;
      set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      n_vec++; if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0) begin n_err++; $display("FAIL first_gnt: got %b%b expected 10", p0_gnt_o, p1_gnt_o); end
      n_vec++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h10) begin n_err++; $display("FAIL first_mem: got en=%b we=%b addr=%h expected 1 0 00000010", mem_en_o, mem_we_o, mem_addr_o); end
      @(negedge clk);
      set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      n_vec++; if (p0_rvalid_o !== 1'b1 || p1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL first_rvalid: got %b%b expected 10", p0_rvalid_o, p1_rvalid_o); end
      n_vec++; if (rdata_o !== 32'hA5A55A5A) begin n_err++; $display("FAIL first_rdata: got %h expected a5a55a5a", rdata_o); end
      @(negedge clk); #1;
      n_vec++; if (p0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rvalid_one_cycle: got %b expected 0", p0_rvalid_o); end
      n_vec++; if (rdata_o !== 32'hA5A55A5A) begin n_err++; $display("FAIL rdata_hold: got %h expected a5a55a5a", rdata_o); end
   endtask

   // Last grant was port 0, so the first tie goes to port 1
   task automatic test_round_robin;
      logic e1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_p0(1'b1, 1'b1, 1'b0, 32'h30, 32'h11111111);
         set_p1(1'b1, 1'b1, 1'b0, 32'h34, 32'h22222222);
         #1;
         e1 = (i % 2 == 0);
         n_vec++; if (p0_gnt_o !== ~e1 || p1_gnt_o !== e1) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b%b expected %b%b", i, p0_gnt_o, p1_gnt_o, ~e1, e1); end
         n_vec++; if (mem_addr_o !== (e1 ? 32'h34 : 32'h30) || mem_wdata_o !== (e1 ? 32'h22222222 : 32'h11111111)) begin n_err++; $display("FAIL rr_mem[%0d]: got addr=%h data=%h", i, mem_addr_o, mem_wdata_o); end
      end
   endtask

   task automatic test_lock_burst;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         set_p0(1'b1, 1'b1, 1'b0, 32'h40, 32'h33333333);
         if (i < 4) set_p1(1'b1, 1'b1, (i < 3), 32'(4 * i), 32'hD0000000 + 32'(i));
         else       set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         #1;
         if (i < 4) begin
            n_vec++; if (p1_gnt_o !== 1'b1 || p0_gnt_o !== 1'b0) begin n_err++; $display("FAIL lock_gnt[%0d]: got %b%b expected 01", i, p0_gnt_o, p1_gnt_o); end
            n_vec++; if (mem_addr_o !== 32'(4 * i) || mem_wdata_o !== 32'hD0000000 + 32'(i) || mem_we_o !== 1'b1) begin n_err++; $display("FAIL lock_mem[%0d]: got addr=%h data=%h", i, mem_addr_o, mem_wdata_o); end
         end else begin
            n_vec++; if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0) begin n_err++; $display("FAIL lock_release: got %b%b expected 10", p0_gnt_o, p1_gnt_o); end
            n_vec++; if (p0_rvalid_o !== 1'b0 || p1_rvalid_o !== 1'b0) begin n_err++; $display("FAIL write_rvalid: got %b%b expected 00", p0_rvalid_o, p1_rvalid_o); end
         end
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      set_p0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      n_vec++; if (p0_gnt_o !== 1'b1 || mem_addr_o !== 32'h20) begin n_err++; $display("FAIL b2b_gnt0: got gnt=%b addr=%h expected 1 00000020", p0_gnt_o, mem_addr_o); end
      @(negedge clk);
      set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_p1(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
      #1;
      n_vec++; if (p1_gnt_o !== 1'b1 || mem_addr_o !== 32'h24) begin n_err++; $display("FAIL b2b_gnt1: got gnt=%b addr=%h expected 1 00000024", p1_gnt_o, mem_addr_o); end
      n_vec++; if (p0_rvalid_o !== 1'b1 || p1_rvalid_o !== 1'b0 || rdata_o !== 32'hCAFE0020) begin n_err++; $display("FAIL b2b_rd0: got rv=%b%b rdata=%h expected 10 cafe0020", p0_rvalid_o, p1_rvalid_o, rdata_o); end
      @(negedge clk);
      set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      n_vec++; if (p1_rvalid_o !== 1'b1 || p0_rvalid_o !== 1'b0 || rdata_o !== 32'hBEEF0024) begin n_err++; $display("FAIL b2b_rd1: got rv=%b%b rdata=%h expected 01 beef0024", p0_rvalid_o, p1_rvalid_o, rdata_o); end
   endtask

   task automatic test_reset_mid_burst;
      @(negedge clk);
      set_p1(1'b1, 1'b0, 1'b1, 32'h24, 32'h0);
      #1;
      n_vec++; if (p1_gnt_o !== 1'b1) begin n_err++; $display("FAIL mid_enter: got %b expected 1", p1_gnt_o); end
      @(negedge clk);
      set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      #1;
      n_vec++; if (p1_gnt_o !== 1'b1 || p0_gnt_o !== 1'b0) begin n_err++; $display("FAIL mid_locked: got %b%b expected 01", p0_gnt_o, p1_gnt_o); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++; if (p1_rvalid_o !== 1'b0 || p0_rvalid_o !== 1'b0) begin n_err++; $display("FAIL mid_rvalid_drop: got %b%b expected 00", p0_rvalid_o, p1_rvalid_o); end
      n_vec++; if (mem_en_o !== 1'b0 || p1_gnt_o !== 1'b0 || rdata_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_out: got en=%b gnt1=%b rdata=%h expected 0", mem_en_o, p1_gnt_o, rdata_o); end
      @(negedge clk);
      rst = 1'b1;
      set_p1(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
      #1;
      n_vec++; if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0) begin n_err++; $display("FAIL mid_tie: got %b%b expected 10", p0_gnt_o, p1_gnt_o); end
      @(negedge clk);
      set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      n_vec++; if (p0_rvalid_o !== 1'b1 || p1_rvalid_o !== 1'b0 || rdata_o !== 32'hA5A55A5A) begin n_err++; $display("FAIL mid_after: got rv=%b%b rdata=%h expected 10 a5a55a5a", p0_rvalid_o, p1_rvalid_o, rdata_o); end
   endtask

   task automatic test_lock_limit;
      logic e0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         set_p0(1'b1, 1'b1, 1'b0, 32'h50, 32'h44444444);
         set_p1(1'b1, 1'b1, 1'b1, 32'h54, 32'h55555555);
         #1;
`ifdef DMARB_LOCK_LIMIT_EN
         e0 = (i == 16);
`else
         e0 = 1'b0;
`endif
         n_vec++; if (p0_gnt_o !== e0 || p1_gnt_o !== ~e0) begin n_err++; $display("FAIL limit_gnt[%0d]: got %b%b expected %b%b", i, p0_gnt_o, p1_gnt_o, e0, ~e0); end
      end
      @(negedge clk);
      set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      n_vec++; if (mem_en_o !== 1'b0) begin n_err++; $display("FAIL limit_idle: got %b expected 0", mem_en_o); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      ram[4] = 32'hA5A55A5A;
      ram[8] = 32'hCAFE0020;
      ram[9] = 32'hBEEF0024;
      mem_rdata_i = 32'h0;
      rst = 1'b0;
      test_reset();
      test_round_robin();
      test_lock_burst();
      test_back_to_back();
      test_reset_mid_burst();
      test_lock_limit();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
